serial_subtractor: RTL and testbench

//  Bit-serial N-bit subtractor built around one full-subtractor cell and a borrow flop.

---
 rtl/serial_subtractor.sv | 172 +++++++++++++++++
 tb/tb_serial_subtractor.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell plus a borrow flop, LSB first.
// Define SERSUB_OVF_EN to add the signed-overflow output ovf and its operand-MSB capture.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state_q,     state_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] a_sh_q,      a_sh_d;
  logic [WIDTH-1:0] b_sh_q,      b_sh_d;
  // Partial difference holds only the WIDTH-1 bits produced before the final cycle.
  logic [WIDTH-2:0] diff_sh_q,   diff_sh_d;
  logic             br_q,        br_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [WIDTH-1:0] diff_q,      diff_d;
  logic             bout_q,      bout_d;
`ifdef SERSUB_OVF_EN
  logic             a_msb_q,     a_msb_d;
  logic             b_msb_q,     b_msb_d;
  logic             ovf_q,       ovf_d;
`endif

  logic bit_x;
  logic bit_y;
  logic d_bit;
  logic br_next;

  // Full-subtractor cell on the current LSBs and the running borrow.
  assign bit_x   = a_sh_q[0];
  assign bit_y   = b_sh_q[0];
  assign d_bit   = bit_x ^ bit_y ^ br_q;
  assign br_next = (~bit_x & bit_y) | (~(bit_x ^ bit_y) & br_q);

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    diff_sh_d   = diff_sh_q;
    br_d        = br_q;
    cnt_d       = cnt_q;
    diff_d      = diff_q;
    bout_d      = bout_q;
`ifdef SERSUB_OVF_EN
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    ovf_d       = ovf_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d    = ST_SHIFT;
          in_ready_d = 1'b0;
          a_sh_d     = a;
          b_sh_d     = b;
          br_d       = bin;
          cnt_d      = '0;
`ifdef SERSUB_OVF_EN
          a_msb_d    = a[WIDTH-1];
          b_msb_d    = b[WIDTH-1];
`endif
        end
      end

      ST_SHIFT: begin
        a_sh_d               = a_sh_q >> 1;
        b_sh_d               = b_sh_q >> 1;
        diff_sh_d            = diff_sh_q >> 1;
        diff_sh_d[WIDTH-2]   = d_bit;
        br_d                 = br_next;
        cnt_d                = cnt_q + CNT_W'(1);
        // Last bit: publish the result straight from the cell outputs.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          diff_d      = {d_bit, diff_sh_q};
          bout_d      = br_next;
`ifdef SERSUB_OVF_EN
          ovf_d       = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
`endif
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
`ifdef SERSUB_OVF_EN
          ovf_d       = 1'b0;
`endif
        end
      end

      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      diff_sh_q   <= '0;
      br_q        <= 1'b0;
      cnt_q       <= '0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
`ifdef SERSUB_OVF_EN
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      diff_sh_q   <= diff_sh_d;
      br_q        <= br_d;
      cnt_q       <= cnt_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
`ifdef SERSUB_OVF_EN
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
`ifdef SERSUB_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8); SERSUB_OVF_EN adds the overflow checks.
module tb_serial_subtractor;

  localparam int unsigned W   = 8;
  localparam int          TMO = 200;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERSUB_OVF_EN
  logic         ovf;
`endif

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef SERSUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: plain (W+1)-bit arithmetic subtraction, borrow is the sign bit.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    logic [W:0] r;
    exp_t       e;
    r      = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
    e.diff = r[W-1:0];
    e.bout = r[W];
`ifdef SERSUB_OVF_EN
    e.ovf  = (x[W-1] != y[W-1]) && (e.diff[W-1] != x[W-1]);
`else
    e.ovf  = 1'b0;
`endif
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi,
                       output int acc_cyc);
    int n;
    n        = 0;
    a        = x;
    b        = y;
    bin      = bi;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready || n >= TMO) break;
      n++;
    end
    check("accept_in_time", 32'(n < TMO), 32'd1);
    @(posedge clk);
    sb_q.push_back(model(x, y, bi));
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < TMO) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("out_valid_in_time", 32'(out_valid), 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(in_ready && sb_q.size() == 0) && n < TMO) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_in_time", 32'(n < TMO), 32'd1);
  endtask

  // Monitor: every output handshake pops and compares one scoreboard entry.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        check("sb_has_entry", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("sb_diff", 32'(diff), 32'(e.diff));
          check("sb_bout", 32'(bout), 32'(e.bout));
`ifdef SERSUB_OVF_EN
          check("sb_ovf", 32'(ovf), 32'(e.ovf));
`endif
        end
      end
    end
  end

  initial begin : stim
    int           acc;
    int           prev_acc;
    int           lat;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         bi;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff",      32'(diff),      32'd0);
    check("rst_bout",      32'(bout),      32'd0);
`ifdef SERSUB_OVF_EN
    check("rst_ovf",       32'(ovf),       32'd0);
`endif
    rst_n = 1'b1;

    // Basic subtract and latency from the accept cycle.
    out_ready = 1'b1;
    issue(8'h05, 8'h03, 1'b0, acc);
    check("busy_in_ready", 32'(in_ready), 32'd0);
    wait_out(lat);
    check("latency_cycles", 32'(lat + 1), 32'(W + 1));
    check("t1_diff", 32'(diff), 32'h02);
    check("t1_bout", 32'(bout), 32'd0);
    wait_idle();

    // Borrow-out cases.
    issue(8'h00, 8'h01, 1'b0, acc);
    wait_out(lat);
    check("t2a_diff", 32'(diff), 32'hFF);
    check("t2a_bout", 32'(bout), 32'd1);
    wait_idle();
    issue(8'hFF, 8'hFF, 1'b1, acc);
    wait_out(lat);
    check("t2b_diff", 32'(diff), 32'hFF);
    check("t2b_bout", 32'(bout), 32'd1);
    wait_idle();

    // Back-pressure in DONE with a stray request that must be ignored.
    out_ready = 1'b0;
    issue(8'h42, 8'h17, 1'b1, acc);
    wait_out(lat);
    a        = 8'h99;
    b        = 8'h11;
    bin      = 1'b0;
    in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("stall_diff",      32'(diff),      32'h2A);
      check("stall_bout",      32'(bout),      32'd0);
      check("stall_in_ready",  32'(in_ready),  32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hs_out_valid_drop", 32'(out_valid), 32'd0);
    check("hs_in_ready_rise",  32'(in_ready),  32'd1);
`ifdef SERSUB_OVF_EN
    check("hs_ovf_clear",      32'(ovf),       32'd0);
`endif
    repeat (2 * W) @(posedge clk);
    #1;
    check("no_phantom_valid", 32'(out_valid), 32'd0);
    check("no_phantom_sb",    32'(sb_q.size()), 32'd0);

    // Reset in the middle of SHIFT discards the operation.
    issue(8'h33, 8'h11, 1'b0, acc);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_diff",      32'(diff),      32'd0);
    check("abort_bout",      32'(bout),      32'd0);
    check("abort_in_ready",  32'(in_ready),  32'd1);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);
    issue(8'h10, 8'h01, 1'b0, acc);
    wait_out(lat);
    check("t4_diff", 32'(diff), 32'h0F);
    check("t4_bout", 32'(bout), 32'd0);
    wait_idle();

    // Back-to-back sweep: corners then random operands.
    prev_acc = -1;
    for (int i = 0; i < 300; i++) begin
      case (i)
        0:       begin x = 8'h00; y = 8'h00; bi = 1'b1; end
        1:       begin x = 8'h5A; y = 8'h5A; bi = 1'b0; end
        2:       begin x = 8'hFF; y = 8'h00; bi = 1'b0; end
        3:       begin x = 8'h00; y = 8'hFF; bi = 1'b1; end
        4:       begin x = 8'h80; y = 8'h7F; bi = 1'b0; end
        5:       begin x = 8'h7F; y = 8'h80; bi = 1'b1; end
        default: begin
          x  = W'($urandom_range(255));
          y  = W'($urandom_range(255));
          bi = 1'($urandom_range(1));
        end
      endcase
      issue(x, y, bi, acc);
      if (prev_acc >= 0) check("issue_interval", 32'(acc - prev_acc), 32'(W + 2));
      prev_acc = acc;
    end
    wait_idle();

`ifdef SERSUB_OVF_EN
    issue(8'h80, 8'h01, 1'b0, acc);
    wait_out(lat);
    check("ovf_a_diff", 32'(diff), 32'h7F);
    check("ovf_a_flag", 32'(ovf),  32'd1);
    wait_idle();
    issue(8'h7F, 8'h01, 1'b0, acc);
    wait_out(lat);
    check("ovf_b_diff", 32'(diff), 32'h7E);
    check("ovf_b_flag", 32'(ovf),  32'd0);
    wait_idle();
`endif

    check("sb_empty_at_end", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
